// File: rtl/mask_overlay.sv
// Mask overlay: pairs each foreground-mask byte with its RGB pixel and paints
// foreground pixels with HIGHLIGHT_COLOR, counting foreground pixels per frame.
module mask_overlay #(
  parameter int          WIDTH           = 720,
  parameter int          HEIGHT          = 540,
  parameter logic [23:0] HIGHLIGHT_COLOR = 24'hFF0000,
  localparam int         CW              = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          in_rd_en_mask,
  input  logic          in_empty_mask,
  input  logic [7:0]    in_dout_mask,
  output logic          in_rd_en_img,
  input  logic          in_empty_img,
  input  logic [23:0]   in_dout_img,
  output logic          out_wr_en,
  input  logic          out_full,
  output logic [23:0]   out_din,
  output logic [CW-1:0] fg_count,
  output logic          frame_done
);

  // One-hot encoding leaves illegal codes that the next-state logic folds back to FETCH.
  typedef enum logic [1:0] {
    FETCH = 2'b01,
    WRITE = 2'b10
  } state_t;

  localparam logic [CW-1:0] LAST_PIXEL = CW'(WIDTH*HEIGHT-1);

  state_t        state, next_state;
  logic [23:0]   pixel;
  logic          fg_flag;
  logic [CW-1:0] pixel_cnt;
  logic [CW-1:0] fg_acc;
  logic          rd_fire;
  logic          wr_fire;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    next_state = state;
    rd_fire    = 1'b0;
    wr_fire    = 1'b0;
    out_din    = '0;
    unique case (state)
      FETCH: begin
        if (!in_empty_mask && !in_empty_img) begin
          rd_fire    = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE: begin
        if (!out_full) begin
          wr_fire    = 1'b1;
          out_din    = pixel;
          next_state = FETCH;
        end
      end
      default: next_state = FETCH;
    endcase
    // Strobes are combinational from state, so they must be forced quiet while reset is held.
    if (reset) begin
      rd_fire = 1'b0;
      wr_fire = 1'b0;
      out_din = '0;
    end
  end

  assign in_rd_en_mask = rd_fire;
  assign in_rd_en_img  = rd_fire;
  assign out_wr_en     = wr_fire;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      pixel      <= '0;
      fg_flag    <= 1'b0;
      pixel_cnt  <= '0;
      fg_acc     <= '0;
      fg_count   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= next_state;
      frame_done <= 1'b0;
      if (rd_fire) begin
        pixel   <= (in_dout_mask != 8'd0) ? HIGHLIGHT_COLOR : in_dout_img;
        fg_flag <= (in_dout_mask != 8'd0);
      end
      if (wr_fire) begin
        if (pixel_cnt == LAST_PIXEL) begin
          pixel_cnt  <= '0;
          fg_count   <= fg_acc + CW'(fg_flag);
          fg_acc     <= '0;
          frame_done <= 1'b1;
        end else begin
          pixel_cnt <= pixel_cnt + 1'b1;
          fg_acc    <= fg_acc + CW'(fg_flag);
        end
      end
    end
  end

endmodule

// File: tb/tb_mask_overlay.sv
// Directed bench for mask_overlay with a 4x2 frame: pixel path, empty/full
// handshakes, frame accounting and mid-frame reset.
module tb_mask_overlay;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int CW = $clog2(W*H+1);

  logic          clock = 1'b0;
  logic          reset;
  logic          in_rd_en_mask, in_empty_mask;
  logic [7:0]    in_dout_mask;
  logic          in_rd_en_img, in_empty_img;
  logic [23:0]   in_dout_img;
  logic          out_wr_en, out_full;
  logic [23:0]   out_din;
  logic [CW-1:0] fg_count;
  logic          frame_done;

  mask_overlay #(.WIDTH(W), .HEIGHT(H), .HIGHLIGHT_COLOR(24'hFF0000)) dut (
    .clock(clock), .reset(reset),
    .in_rd_en_mask(in_rd_en_mask), .in_empty_mask(in_empty_mask), .in_dout_mask(in_dout_mask),
    .in_rd_en_img(in_rd_en_img), .in_empty_img(in_empty_img), .in_dout_img(in_dout_img),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
    .fg_count(fg_count), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  mask;
    logic [23:0] img;
    logic [23:0] exp;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts in FETCH at posedge+1; pops one pixel then checks its write.
  task automatic do_pixel(input logic [7:0] m, input logic [23:0] im, input logic [23:0] ex,
                          input string tag);
    in_dout_mask  = m;
    in_dout_img   = im;
    in_empty_mask = 1'b0;
    in_empty_img  = 1'b0;
    out_full      = 1'b0;
    #1;
    check({tag, " fetch strobes"}, {in_rd_en_mask, in_rd_en_img, out_wr_en}, 3'b110);
    tick();
    in_empty_mask = 1'b1;
    in_empty_img  = 1'b1;
    #1;
    check({tag, " write strobes"}, {in_rd_en_mask, in_rd_en_img, out_wr_en}, 3'b001);
    check({tag, " out_din"}, out_din, ex);
    tick();
  endtask

  vec_t frame1[8];

  initial begin
    frame1[0] = '{8'hFF, 24'h123456, 24'hFF0000};
    frame1[1] = '{8'h00, 24'hABCDEF, 24'hABCDEF};
    frame1[2] = '{8'hFF, 24'h000001, 24'hFF0000};
    frame1[3] = '{8'hFF, 24'h777777, 24'hFF0000};
    frame1[4] = '{8'h00, 24'h00FF00, 24'h00FF00};
    frame1[5] = '{8'h00, 24'hFF0001, 24'hFF0001};
    frame1[6] = '{8'hFF, 24'h0000FF, 24'hFF0000};
    frame1[7] = '{8'h00, 24'h314159, 24'h314159};

    // Reset with FIFOs ready: every strobe must stay quiet.
    reset = 1'b1; in_empty_mask = 1'b0; in_empty_img = 1'b0; out_full = 1'b0;
    in_dout_mask = 8'hFF; in_dout_img = 24'h123456;
    #1;
    check("reset strobes", {in_rd_en_mask, in_rd_en_img, out_wr_en}, 3'b000);
    check("reset out_din", out_din, 24'h0);
    check("reset fg_count", fg_count, 0);
    check("reset frame_done", frame_done, 1'b0);
    tick();
    in_empty_mask = 1'b1; in_empty_img = 1'b1;
    reset = 1'b0;
    tick();

    // Single foreground pixel.
    do_pixel(8'hFF, 24'h123456, 24'hFF0000, "single");

    // Image FIFO empty for 5 cycles while mask is available.
    in_dout_mask = 8'h00; in_dout_img = 24'hABCDEF;
    in_empty_mask = 1'b0; in_empty_img = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("asym empty strobes", {in_rd_en_mask, in_rd_en_img, out_wr_en}, 3'b000);
      tick();
    end
    do_pixel(8'h00, 24'hABCDEF, 24'hABCDEF, "background");

    // Backpressure for 6 cycles with both inputs still available; mask 01 is foreground.
    in_dout_mask = 8'h01; in_dout_img = 24'h55AA33;
    in_empty_mask = 1'b0; in_empty_img = 1'b0; out_full = 1'b0;
    #1;
    check("bp fetch strobes", {in_rd_en_mask, in_rd_en_img, out_wr_en}, 3'b110);
    tick();
    out_full = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("bp stall strobes", {in_rd_en_mask, in_rd_en_img, out_wr_en}, 3'b000);
      check("bp stall out_din", out_din, 24'h0);
      tick();
    end
    out_full = 1'b0; in_empty_mask = 1'b1; in_empty_img = 1'b1;
    #1;
    check("bp release strobes", {in_rd_en_mask, in_rd_en_img, out_wr_en}, 3'b001);
    check("bp release out_din", out_din, 24'hFF0000);
    tick();

    // Fourth pixel held in WRITE, then reset mid-frame.
    in_dout_mask = 8'h00; in_dout_img = 24'hDEAD01;
    in_empty_mask = 1'b0; in_empty_img = 1'b0;
    #1;
    check("held fetch strobes", {in_rd_en_mask, in_rd_en_img, out_wr_en}, 3'b110);
    tick();
    out_full = 1'b1;
    #1;
    check("held stall strobes", {in_rd_en_mask, in_rd_en_img, out_wr_en}, 3'b000);
    tick();
    reset = 1'b1; out_full = 1'b0;
    #1;
    check("midreset strobes", {in_rd_en_mask, in_rd_en_img, out_wr_en}, 3'b000);
    check("midreset out_din", out_din, 24'h0);
    check("midreset frame_done", frame_done, 1'b0);
    check("midreset fg_count", fg_count, 0);
    tick();
    reset = 1'b0; in_empty_mask = 1'b1; in_empty_img = 1'b1;
    #1;
    check("post reset idle", {in_rd_en_mask, in_rd_en_img, out_wr_en}, 3'b000);
    tick();

    // Full frame from the table; frame_done must not appear early.
    for (int i = 0; i < 8; i++) begin
      do_pixel(frame1[i].mask, frame1[i].img, frame1[i].exp, $sformatf("frame1[%0d]", i));
      if (i < 7) check($sformatf("frame1[%0d] frame_done", i), frame_done, 1'b0);
    end
    check("frame1 frame_done", frame_done, 1'b1);
    check("frame1 fg_count", fg_count, 4);
    tick();
    check("frame1 frame_done pulse", frame_done, 1'b0);
    check("frame1 fg_count hold", fg_count, 4);

    // Second frame, all background.
    for (int i = 0; i < 8; i++) begin
      logic [23:0] px;
      px = 24'h111111 * (i + 1);
      do_pixel(8'h00, px, px, $sformatf("frame2[%0d]", i));
      if (i < 7) check($sformatf("frame2[%0d] frame_done", i), frame_done, 1'b0);
      if (i < 7) check($sformatf("frame2[%0d] fg_count hold", i), fg_count, 4);
    end
    check("frame2 frame_done", frame_done, 1'b1);
    check("frame2 fg_count", fg_count, 0);
    tick();
    check("frame2 frame_done pulse", frame_done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mask_overlay.md
Name: mask_overlay

Overview:
- Consumer of the 8-bit foreground-mask stream produced by the background-subtraction stage.
- Reads one mask byte and the matching 24-bit RGB pixel from two FWFT FIFOs.
- For foreground pixels it writes HIGHLIGHT_COLOR to a 24-bit output FIFO; for background pixels it writes the original pixel unchanged.
- Also counts pixels per frame, reports the per-frame foreground pixel count, and pulses at frame end.

Parameters:
- WIDTH, 720, pixels per line.
- HEIGHT, 540, lines per frame.
- HIGHLIGHT_COLOR, 24'hFF0000, RGB value substituted for foreground pixels.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_rd_en_mask  out  1  pop strobe, mask FIFO.
- in_empty_mask  in  1  mask FIFO empty.
- in_dout_mask  in  8  mask byte, FWFT (valid while not empty).
- in_rd_en_img  out  1  pop strobe, image FIFO.
- in_empty_img  in  1  image FIFO empty.
- in_dout_img  in  24  RGB pixel, FWFT.
- out_wr_en  out  1  push strobe, output FIFO.
- out_full  in  1  output FIFO full.
- out_din  out  24  output pixel.
- fg_count  out  $clog2(WIDTH*HEIGHT+1)  foreground pixel count of the last completed frame.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.

Behaviour:
- Reset (async, active-high):
  - State goes to FETCH.
  - Pixel register = 0, pixel counter = 0, foreground accumulator = 0.
  - fg_count = 0, frame_done = 0.
  - All strobes are 0 and out_din = 0 while reset is asserted.
- Two-state FSM, FETCH and WRITE.
- FETCH:
  - Fires only when in_empty_mask=0 AND in_empty_img=0.
  - On fire, in_rd_en_mask=1 and in_rd_en_img=1 in the same cycle (combinational). Both FIFOs are always popped together, never one alone.
  - Pixel register <= (in_dout_mask != 0) ? HIGHLIGHT_COLOR : in_dout_img. Any nonzero mask byte counts as foreground.
  - fg flag register <= (in_dout_mask != 0).
  - Next state is WRITE.
  - Otherwise the read strobes stay 0 and the FSM stays in FETCH.
- WRITE:
  - Fires only when out_full=0. On fire, out_wr_en=1 and out_din = pixel register, then next state is FETCH.
  - When out_full=1, out_wr_en=0, out_din=0, and the FSM stays in WRITE, holding the pixel indefinitely.
- Outside a WRITE fire: out_din=0 and out_wr_en=0.
- Read strobes are 0 in every state except a FETCH fire.
- Throughput: at most 1 pixel per 2 cycles. Latency from pop to push is 1 cycle when the output FIFO is not full.
- Counting, on each WRITE fire:
  - If pixel counter == WIDTH*HEIGHT-1 (last pixel of the frame):
    - pixel counter <= 0.
    - fg_count <= accumulator + fg flag.
    - accumulator <= 0.
    - frame_done <= 1, registered, so it is high for exactly the cycle after the last write.
  - Otherwise: pixel counter += 1, accumulator += fg flag.
- frame_done is 0 in every other cycle. fg_count holds its value until the next frame completes.
- Counter and accumulator widths are $clog2(WIDTH*HEIGHT+1) bits; no overflow is possible within one frame.
- Reset mid-frame: the partial frame is discarded, counters return to 0, and fg_count returns to 0. A pixel held in WRITE is lost and is never written.
- Empty/full interaction: a FIFO going empty never affects a pending WRITE; out_full never affects a FETCH already completed.
- Illegal state encoding recovers to FETCH with all strobes 0.

Test Plan (bench uses WIDTH=4, HEIGHT=2, HIGHLIGHT_COLOR=24'hFF0000):
- Single pixel path:
  - Stimulus: mask=8'hFF, img=24'h123456, both FIFOs non-empty, out_full=0.
  - Required: both rd_en pulse together in one cycle; next cycle out_wr_en=1 with out_din=24'hFF0000.
- Background pass-through:
  - Stimulus: mask=8'h00, img=24'hABCDEF.
  - Required: out_din=24'hABCDEF. Also mask=8'h01 → out_din=24'hFF0000 (nonzero counts as foreground).
- Asymmetric empty:
  - Stimulus: mask FIFO non-empty, image FIFO empty for 5 cycles.
  - Required: no rd_en on either FIFO, no write; processing starts the cycle the image FIFO goes non-empty.
- Backpressure:
  - Stimulus: out_full=1 for 6 cycles after a FETCH.
  - Required: out_wr_en=0 and no reads during that time; the held pixel is written in the first cycle with out_full=0, and its value is unchanged.
- Frame boundary:
  - Stimulus: 8 pixels with mask pattern FF,00,FF,FF,00,00,FF,00.
  - Required: frame_done high for exactly one cycle, the cycle after the 8th write; fg_count=4. A second frame of all 00 gives fg_count=0.
- Mid-frame reset:
  - Stimulus: assert reset after 3 writes while in WRITE.
  - Required: all outputs 0 immediately; after release, a full 8-pixel frame gives frame_done after the 8th new write, and the held pixel is never emitted.
